mul16_seq: RTL and testbench

MUL16_SEQ -- requirements
Module: mul16_seq

---
 rtl/mul16_seq.sv | 128 ++++++++++++
 tb/tb_mul16_seq.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mul16_seq.sv
// mul16_seq: 16x16 unsigned sequential shift-and-add multiplier.
// Each clock performs one partial-product step through a single 16-bit
// ripple adder. The carry-out is kept as bit 16 of the partial sum, and
// {carry, high, low} is then shifted right by one.
// Optional feature: define MUL16_ZERO_SKIP_EN to finish in one cycle when
// either operand is zero at the accepting edge.
module mul16_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic        ready,
  output logic        done,
  output logic [31:0] out
);

  localparam int unsigned OP_W  = 16;
  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(OP_W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [OP_W-1:0]  mcand;
  logic [OP_W-1:0]  mcand_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic [31:0]      out_next;

  // out doubles as the accumulator: out[31:16] is the high half and
  // out[15:0] is the low half, which holds the multiplier as it shifts out.
  logic [OP_W-1:0]  acc_hi;
  logic [OP_W-1:0]  acc_lo;
  logic [OP_W-1:0]  addend;
  logic [OP_W-1:0]  sum;
  logic [OP_W:0]    carry;
  logic [OP_W:0]    sum17;

  assign acc_hi = out[31:16];
  assign acc_lo = out[15:0];

  // Single 16-bit ripple adder: high half plus the multiplicand, gated by the multiplier LSB.
  always_comb begin
    addend   = acc_lo[0] ? mcand : '0;
    sum      = '0;
    carry    = '0;
    for (int i = 0; i < int'(OP_W); i++) begin
      sum[i]     = acc_hi[i] ^ addend[i] ^ carry[i];
      carry[i+1] = (acc_hi[i] & addend[i]) | (carry[i] & (acc_hi[i] ^ addend[i]));
    end
    sum17 = {carry[OP_W], sum};
  end

  // FSM state and registered status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      ready <= 1'b1;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      ready <= (state_next == IDLE);
      done  <= (state_next == DONE);
    end
  end

  // Datapath registers: multiplicand, step counter and accumulator.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcand <= '0;
      cnt   <= '0;
      out   <= '0;
    end else begin
      mcand <= mcand_next;
      cnt   <= cnt_next;
      out   <= out_next;
    end
  end

  // Next-state and datapath next values.
  always_comb begin
    state_next = state;
    mcand_next = mcand;
    cnt_next   = cnt;
    out_next   = out;
    case (state)
      IDLE: begin
        if (start) begin
          mcand_next = a;
          cnt_next   = '0;
`ifdef MUL16_ZERO_SKIP_EN
          if ((a == '0) || (b == '0)) begin
            state_next = DONE;
            out_next   = '0;
          end else begin
            state_next = RUN;
            out_next   = {16'h0000, b};
          end
`else
          state_next = RUN;
          out_next   = {16'h0000, b};
`endif
        end
      end
      RUN: begin
        // Shift {carry, high, low} right by one; the low half's LSB is discarded.
        out_next = {sum17[OP_W:1], sum17[0], acc_lo[OP_W-1:1]};
        cnt_next = cnt + CNT_W'(1);
        if (cnt == LAST_STEP) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mul16_seq.sv
// tb_mul16_seq: self-checking bench for mul16_seq.
// The reference product comes from plain 32-bit arithmetic.
module tb_mul16_seq;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        ready;
  logic        done;
  logic [31:0] out;

  int tests;
  int fails;

  mul16_seq dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .a     (a),
    .b     (b),
    .ready (ready),
    .done  (done),
    .out   (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] va;
    logic [15:0] vb;
    logic [31:0] vexp;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Negedge samples counted from the first negedge after the accepting edge.
  function automatic int exp_lat(input logic [15:0] ea, input logic [15:0] eb);
`ifdef MUL16_ZERO_SKIP_EN
    if ((ea == 16'h0) || (eb == 16'h0)) return 0;
`endif
    if (ea === eb) return 16;
    return 16;
  endfunction

  // Full transaction: start for one cycle, wait for done, check result and handshake.
  task automatic mul_op(input string name, input logic [15:0] ta, input logic [15:0] tb_v,
                        input logic [31:0] exp);
    int lat;
    @(negedge clk);
    check({name, "_ready_idle"}, 32'(ready), 32'd1);
    a = ta;
    b = tb_v;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = $urandom();
    b = $urandom();
    lat = 0;
    check({name, "_ready_low"}, 32'(ready), 32'd0);
    while ((done !== 1'b1) && (lat < 40)) begin
      @(negedge clk);
      lat++;
    end
    check({name, "_latency"}, 32'(lat), 32'(exp_lat(ta, tb_v)));
    check({name, "_product"}, out, exp);
    @(negedge clk);
    check({name, "_done_one_cycle"}, 32'(done), 32'd0);
    check({name, "_ready_back"}, 32'(ready), 32'd1);
    check({name, "_out_hold"}, out, exp);
  endtask

  initial begin
    int k;
    int ndone;
    int dq[$];
    logic [31:0] got;
    logic [15:0] ra;
    logic [15:0] rb;

    tests = 0;
    fails = 0;
    vecs[0] = '{16'h0003, 16'h0005, 32'h0000000F};
    vecs[1] = '{16'hFFFF, 16'hFFFF, 32'hFFFE0001};
    vecs[2] = '{16'h8000, 16'h0002, 32'h00010000};
    vecs[3] = '{16'h0000, 16'h00FF, 32'h00000000};
    vecs[4] = '{16'h0001, 16'h0001, 32'h00000001};
    vecs[5] = '{16'hFFFF, 16'h0001, 32'h0000FFFF};
    vecs[6] = '{16'h1234, 16'h5678, 32'h06260060};
    vecs[7] = '{16'h8000, 16'h8000, 32'h40000000};

    reset = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    #1;
    check("reset_ready", 32'(ready), 32'd1);
    check("reset_done", 32'(done), 32'd0);
    check("reset_out", out, 32'd0);
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Directed vector table.
    for (int i = 0; i < 8; i++) begin
      mul_op($sformatf("vec%0d", i), vecs[i].va, vecs[i].vb, vecs[i].vexp);
    end

    // Random operands against the arithmetic model, zeros mixed in.
    for (int i = 0; i < 20; i++) begin
      ra = 16'($urandom());
      rb = 16'($urandom());
      if ($urandom_range(0, 7) == 0) ra = 16'h0;
      if ($urandom_range(0, 7) == 0) rb = 16'h0;
      mul_op($sformatf("rnd%0d", i), ra, rb, 32'(ra) * 32'(rb));
    end

    // Start during RUN with changing operands is ignored.
    @(negedge clk);
    a = 16'd7;
    b = 16'd9;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    a = 16'd1;
    b = 16'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = 16'hAAAA;
    b = 16'h5555;
    ndone = 0;
    got = '0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        ndone++;
        if (ndone == 1) got = out;
      end
    end
    check("ignore_start_ndone", 32'(ndone), 32'd1);
    check("ignore_start_product", got, 32'h0000003F);
    check("ignore_start_ready", 32'(ready), 32'd1);

    // Start held high: one product every 18 cycles, one IDLE cycle after each done.
    @(negedge clk);
    a = 16'h00AB;
    b = 16'h0CDE;
    start = 1'b1;
    dq.delete();
    for (k = 1; k <= 60; k++) begin
      @(negedge clk);
      if ((dq.size() > 0) && (dq[dq.size()-1] == k - 1)) begin
        check("hold_ready_after_done", 32'(ready), 32'd1);
      end
      if ((dq.size() > 0) && (dq[dq.size()-1] == k - 2)) begin
        check("hold_reaccept", 32'(ready), 32'd0);
      end
      if (done === 1'b1) begin
        check("hold_product", out, 32'h000AB * 32'h0CDE);
        dq.push_back(k);
      end
    end
    check("hold_ndone", 32'(dq.size()), 32'd3);
    if (dq.size() == 3) begin
      check("hold_first_done", 32'(dq[0]), 32'd17);
      check("hold_spacing1", 32'(dq[1] - dq[0]), 32'd18);
      check("hold_spacing2", 32'(dq[2] - dq[1]), 32'd18);
    end
    start = 1'b0;
    k = 0;
    while ((done !== 1'b1) && (k < 40)) begin
      @(negedge clk);
      k++;
    end
    check("hold_drain", 32'(done), 32'd1);
    @(negedge clk);

    // Reset in the middle of RUN aborts the operation.
    @(negedge clk);
    a = 16'h1234;
    b = 16'h5678;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort_out", out, 32'd0);
    check("abort_ready", 32'(ready), 32'd1);
    check("abort_done", 32'(done), 32'd0);
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done === 1'b1) ndone++;
    end
    check("abort_no_done", 32'(ndone), 32'd0);
    reset = 1'b0;
    a = 16'd2;
    b = 16'd2;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("post_reset_accept", 32'(ready), 32'd0);
    k = 0;
    while ((done !== 1'b1) && (k < 40)) begin
      @(negedge clk);
      k++;
    end
    check("post_reset_latency", 32'(k), 32'd16);
    check("post_reset_product", out, 32'd4);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Global watchdog so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
